// File: rtl/d_mem_sized_if.sv
// Bus between the MEM-stage datapath (master) and the sized data memory (slave).
interface d_mem_sized_if;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Ready;
    logic        Error;
    logic        Busy;

    modport master (
        output MemRead, MemWrite, Size, Unsigned, Address, WriteData,
        input  ReadData, Ready, Error, Busy
    );

    modport slave (
        input  MemRead, MemWrite, Size, Unsigned, Address, WriteData,
        output ReadData, Ready, Error, Busy
    );
endinterface

// File: rtl/d_mem_sized.sv
// Sized data memory for the MIPS MEM stage: byte/half/word loads and stores,
// little-endian lanes, sign/zero extension, alignment rejection and a
// programmable number of wait states before each array access.
// Optional feature: define D_MEM_BOUNDS_CHECK_EN to reject addresses with any
// bit set above the array's byte range instead of wrapping.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for MemRead/MemWrite; request latched on accept
// ST_WAIT   | burning wait states, counter runs down to zero
// ST_ACCESS | array read/write performed at the closing edge
module d_mem_sized #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input logic            clock,
    input logic            reset_n,
    d_mem_sized_if.slave   bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int BW = AW + 2;
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q;
    logic [BW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [1:0]    size_q;
    logic          uns_q, rd_q, wr_q;
`ifdef D_MEM_BOUNDS_CHECK_EN
    logic          upper_q;
`endif

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   rdata_q;
    logic          ready_q, error_q;

    logic          req;
    logic [AW-1:0] idx;
    logic          acc_err;
    logic [31:0]   rword, load_val, wlanes;
    logic [15:0]   shifted;
    logic [3:0]    be;

    assign req = bus.MemRead | bus.MemWrite;
    assign idx = addr_q[BW-1:2];

    assign bus.Busy     = (state_q != ST_IDLE);
    assign bus.Ready    = ready_q;
    assign bus.Error    = error_q;
    assign bus.ReadData = rdata_q;

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // FSM next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req) state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
            ST_WAIT:   if (cnt_q == 4'd0) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Wait-state down-counter, loaded on acceptance
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= 4'd0;
        end else if (state_q == ST_IDLE && req) begin
            cnt_q <= CNT_LOAD;
        end else if (state_q == ST_WAIT && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Request capture; only the bits that address the array are kept
    always_ff @(posedge clock) begin
        if (state_q == ST_IDLE && req) begin
            addr_q  <= bus.Address[BW-1:0];
            wdata_q <= bus.WriteData;
            size_q  <= bus.Size;
            uns_q   <= bus.Unsigned;
            rd_q    <= bus.MemRead;
            wr_q    <= bus.MemWrite;
`ifdef D_MEM_BOUNDS_CHECK_EN
            upper_q <= (bus.Address >> BW) != 32'd0;
`endif
        end
    end

    // Rejection check on the latched request (illegal size, misalignment, read+write)
    always_comb begin
        acc_err = rd_q & wr_q;
        case (size_q)
            2'b00:   ;
            2'b01:   if (addr_q[0]) acc_err = 1'b1;
            2'b10:   if (addr_q[1:0] != 2'b00) acc_err = 1'b1;
            default: acc_err = 1'b1;
        endcase
`ifdef D_MEM_BOUNDS_CHECK_EN
        if (upper_q) acc_err = 1'b1;
`endif
    end

    // Lane selection/extension for loads and lane enables for stores
    always_comb begin
        rword    = mem[idx];
        shifted  = 16'(rword >> {addr_q[1:0], 3'b000});
        load_val = rword;
        be       = 4'b1111;
        wlanes   = wdata_q;
        case (size_q)
            2'b00: begin
                load_val = uns_q ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
                be       = 4'b0001 << addr_q[1:0];
                wlanes   = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                load_val = uns_q ? {16'd0, shifted} : {{16{shifted[15]}}, shifted};
                be       = addr_q[1] ? 4'b1100 : 4'b0011;
                wlanes   = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    // Array write; a reset at the access edge cancels the store
    always_ff @(posedge clock) begin
        if (reset_n && state_q == ST_ACCESS && wr_q && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
            end
        end
    end

    // Completion pulse, error flag and held load result
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ready_q <= 1'b0;
            error_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            ready_q <= (state_q == ST_ACCESS);
            error_q <= (state_q == ST_ACCESS) && acc_err;
            if (state_q == ST_ACCESS && rd_q && !acc_err) rdata_q <= load_val;
        end
    end
endmodule

// File: tb/tb_d_mem_sized.sv
// Directed bench: a vector table on a 2-wait-state instance, plus hand-written
// back-to-back (0 wait states) and reset-abort sequences.
module tb_d_mem_sized;
    logic clock = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    always #5 clock = ~clock;

    d_mem_sized_if bus_a();
    d_mem_sized_if bus_b();

    d_mem_sized #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut_a (
        .clock(clock), .reset_n(rst_a_n), .bus(bus_a.slave));
    d_mem_sized #(.DEPTH_WORDS(16), .WAIT_STATES(0)) dut_b (
        .clock(clock), .reset_n(rst_b_n), .bus(bus_b.slave));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        bit          rd;
        bit          wr;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input bit rd, input bit wr, input logic [1:0] size,
                                input bit uns, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rd, input bit exp_err);
        vec_t v;
        v.name = name; v.rd = rd; v.wr = wr; v.size = size; v.uns = uns;
        v.addr = addr; v.wdata = wdata; v.exp_rd = exp_rd; v.exp_err = exp_err;
        return v;
    endfunction

    // One full access on dut_a; expects Ready after 3 edges with Busy high until then.
    task automatic run_a(input vec_t v);
        int edges;
        bit busy_ok;
        @(negedge clock);
        bus_a.MemRead = v.rd; bus_a.MemWrite = v.wr; bus_a.Size = v.size;
        bus_a.Unsigned = v.uns; bus_a.Address = v.addr; bus_a.WriteData = v.wdata;
        @(posedge clock);
        #1;
        bus_a.MemRead = 1'b0; bus_a.MemWrite = 1'b0;
        edges = 0;
        busy_ok = 1'b1;
        do begin
            @(posedge clock);
            edges++;
            @(negedge clock);
            if (!bus_a.Ready && !bus_a.Busy) busy_ok = 1'b0;
        end while (!bus_a.Ready && edges < 20);
        check({v.name, " ready"}, 32'(bus_a.Ready), 32'd1);
        check({v.name, " latency"}, 32'(edges), 32'd3);
        check({v.name, " busy"}, 32'({busy_ok, bus_a.Busy}), 32'b10);
        check({v.name, " error"}, 32'(bus_a.Error), 32'(v.exp_err));
        check({v.name, " rdata"}, bus_a.ReadData, v.exp_rd);
    endtask

    localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SX = 2'b11;

    initial begin
        bit bc;
`ifdef D_MEM_BOUNDS_CHECK_EN
        bc = 1'b1;
`else
        bc = 1'b0;
`endif
        vecs.push_back(mk("sw_10",    0, 1, SW, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0));
        vecs.push_back(mk("lw_10",    1, 0, SW, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0));
        vecs.push_back(mk("sb_11",    0, 1, SB, 0, 32'h11,  32'h1234567F, 32'hDEADBEEF, 0));
        vecs.push_back(mk("lw_10b",   1, 0, SW, 0, 32'h10,  32'h0,        32'hDEAD7FEF, 0));
        vecs.push_back(mk("lb_13",    1, 0, SB, 0, 32'h13,  32'h0,        32'hFFFFFFDE, 0));
        vecs.push_back(mk("lbu_13",   1, 0, SB, 1, 32'h13,  32'h0,        32'h000000DE, 0));
        vecs.push_back(mk("lh_12",    1, 0, SH, 0, 32'h12,  32'h0,        32'hFFFFDEAD, 0));
        vecs.push_back(mk("lhu_10",   1, 0, SH, 1, 32'h10,  32'h0,        32'h00007FEF, 0));
        vecs.push_back(mk("lb_10",    1, 0, SB, 0, 32'h10,  32'h0,        32'hFFFFFFEF, 0));
        vecs.push_back(mk("lbu_11",   1, 0, SB, 1, 32'h11,  32'h0,        32'h0000007F, 0));
        vecs.push_back(mk("sh_12",    0, 1, SH, 0, 32'h12,  32'hABCD8001, 32'h0000007F, 0));
        vecs.push_back(mk("lw_10c",   1, 0, SW, 0, 32'h10,  32'h0,        32'h80017FEF, 0));
        vecs.push_back(mk("lh_21",    1, 0, SH, 0, 32'h21,  32'h0,        32'h80017FEF, 1));
        vecs.push_back(mk("lw_22",    1, 0, SW, 0, 32'h22,  32'h0,        32'h80017FEF, 1));
        vecs.push_back(mk("size11",   1, 0, SX, 0, 32'h10,  32'h0,        32'h80017FEF, 1));
        vecs.push_back(mk("rd_wr",    1, 1, SW, 0, 32'h10,  32'h0,        32'h80017FEF, 1));
        vecs.push_back(mk("sw_12",    0, 1, SW, 0, 32'h12,  32'h11111111, 32'h80017FEF, 1));
        vecs.push_back(mk("sh_13",    0, 1, SH, 0, 32'h13,  32'h00002222, 32'h80017FEF, 1));
        vecs.push_back(mk("lw_10d",   1, 0, SW, 1, 32'h10,  32'h0,        32'h80017FEF, 0));
        vecs.push_back(mk("sw_00",    0, 1, SW, 0, 32'h0,   32'h01020304, 32'h80017FEF, 0));
        vecs.push_back(mk("sw_400",   0, 1, SW, 0, 32'h400, 32'hCAFEF00D, 32'h80017FEF, bc));
        vecs.push_back(mk("lw_00",    1, 0, SW, 0, 32'h0,   32'h0,
                          bc ? 32'h01020304 : 32'hCAFEF00D, 0));
        vecs.push_back(mk("lhu_402",  1, 0, SH, 1, 32'h402, 32'h0,
                          bc ? 32'h01020304 : 32'h0000CAFE, bc));

        bus_a.MemRead = 0; bus_a.MemWrite = 0; bus_a.Size = 0; bus_a.Unsigned = 0;
        bus_a.Address = 0; bus_a.WriteData = 0;
        bus_b.MemRead = 0; bus_b.MemWrite = 0; bus_b.Size = 0; bus_b.Unsigned = 0;
        bus_b.Address = 0; bus_b.WriteData = 0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_a outputs", {bus_a.ReadData[28:0], bus_a.Ready, bus_a.Error, bus_a.Busy}, 32'd0);
        check("rst_a rdata", bus_a.ReadData, 32'd0);
        check("rst_b outputs", {bus_b.ReadData[28:0], bus_b.Ready, bus_b.Error, bus_b.Busy}, 32'd0);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_a(vecs[i]);

        // Zero wait states, back-to-back SW/LW/LW on one address
        @(negedge clock);
        bus_b.MemWrite = 1; bus_b.Size = SW; bus_b.Address = 32'h8; bus_b.WriteData = 32'h5A5AC3C3;
        @(posedge clock);
        @(negedge clock);
        check("b2b c1 busy/ready", {bus_b.Busy, bus_b.Ready}, 32'b10);
        bus_b.MemWrite = 0; bus_b.MemRead = 1;
        @(posedge clock);
        @(negedge clock);
        check("b2b sw done", {bus_b.Busy, bus_b.Ready, bus_b.Error}, 32'b010);
        @(posedge clock);
        @(negedge clock);
        check("b2b c3 busy/ready", {bus_b.Busy, bus_b.Ready}, 32'b10);
        @(posedge clock);
        @(negedge clock);
        check("b2b lw1 ready", {bus_b.Busy, bus_b.Ready, bus_b.Error}, 32'b010);
        check("b2b lw1 rdata", bus_b.ReadData, 32'h5A5AC3C3);
        @(posedge clock);
        @(negedge clock);
        check("b2b c5 busy/ready", {bus_b.Busy, bus_b.Ready}, 32'b10);
        bus_b.MemRead = 0;
        @(posedge clock);
        @(negedge clock);
        check("b2b lw2 ready", {bus_b.Busy, bus_b.Ready, bus_b.Error}, 32'b010);
        check("b2b lw2 rdata", bus_b.ReadData, 32'h5A5AC3C3);
        @(posedge clock);
        @(negedge clock);
        check("b2b idle", {bus_b.Busy, bus_b.Ready}, 32'b00);

        // Reset during WAIT of a store aborts it
        @(negedge clock);
        bus_a.MemWrite = 1; bus_a.Size = SW; bus_a.Address = 32'h10; bus_a.WriteData = 32'h55555555;
        @(posedge clock);
        @(negedge clock);
        bus_a.MemWrite = 0;
        check("abort busy in wait", 32'(bus_a.Busy), 32'd1);
        rst_a_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("abort outputs", {bus_a.ReadData[28:0], bus_a.Ready, bus_a.Error, bus_a.Busy}, 32'd0);
        check("abort rdata", bus_a.ReadData, 32'd0);
        rst_a_n = 1'b1;
        run_a(mk("lw_after_abort", 1, 0, SW, 0, 32'h10, 32'h0, 32'h80017FEF, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/d_mem_sized.md
# d_mem_sized

Parametrised data memory for the MIPS datapath, replacing the single-cycle word-only data memory. Supports byte, halfword and word loads and stores (LB/LBU/LH/LHU/LW/SB/SH/SW) with little-endian lane selection, sign/zero extension and alignment checking. Accesses run through a small FSM with a configurable wait-state counter, so the datapath stalls on `Busy` and resumes on `Ready`. Sits in the MEM stage between the ALU result/rt operand and the write-back mux.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words; power of two, 16..65536.
- `WAIT_STATES`, 1: extra cycles inserted before the array access, 0..15.
- `clock` input 1: single clock; all state updates on rising edge.
- `reset_n` input 1: reset, synchronous, active-low.
- `MemRead` input 1: load request, sampled only in IDLE.
- `MemWrite` input 1: store request, sampled only in IDLE.
- `Size` input 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `Unsigned` input 1: 1 zero-extends loads, 0 sign-extends; ignored for word and stores.
- `Address` input 32: byte address.
- `WriteData` input 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `ReadData` output 32: extended load result; held until the next successful load completes.
- `Ready` output 1: one-cycle completion pulse.
- `Error` output 1: one-cycle pulse coincident with `Ready` when the access was rejected.
- `Busy` output 1: high whenever FSM is not IDLE.

## Operation
- States: IDLE, WAIT, ACCESS. `Busy` = (state != IDLE), combinational from state.
- IDLE: if `MemRead` or `MemWrite` is high at an edge, latch Address, WriteData, Size, Unsigned, op; go to WAIT (counter loaded with WAIT_STATES-1) if WAIT_STATES>0, else ACCESS.
- WAIT: decrement counter each edge; at 0 go to ACCESS. Inputs ignored.
- ACCESS: at edge perform access from latched values, return to IDLE, assert `Ready` (registered) for the following cycle.
- Rejected (Error=1, no array write, ReadData unchanged): Size=11; half with Address[0]=1; word with Address[1:0]!=00; `MemRead` and `MemWrite` both high at acceptance. Rejected accesses take the same latency as legal ones.
- Word index = Address[log2(DEPTH_WORDS)+1:2]; higher bits ignored (wrap-around).
- Store: per-byte write enables; byte to lane Address[1:0], half to lanes {Address[1],0}+1..0; other lanes preserved.
- Load: select lane(s) by Address[1:0], then sign- or zero-extend to 32 bits.
- Memory array is not reset; contents undefined until written.

## Timing
- Request sampled at edge k → `Ready` high in cycle after edge k+1+WAIT_STATES; WAIT_STATES=0 gives `Ready` one cycle after acceptance.
- Store visible to a load accepted in the `Ready` cycle or later.
- Back-to-back: a new request may be accepted at the edge ending the `Ready` cycle (FSM already IDLE).
- Reset (`reset_n`=0 at an edge): state IDLE, counter 0, `Ready`=0, `Error`=0, `ReadData`=0, `Busy`=0. Reset during WAIT/ACCESS aborts; pending store is not performed.
- Requests while `Busy` are ignored, not queued; the datapath holds them until `Ready`.

## Configuration
- `D_MEM_BOUNDS_CHECK_EN` defined: any set bit in Address above bit log2(DEPTH_WORDS)+1 rejects the access (Error=1, no write), same latency.
- Not defined: upper address bits ignored; addresses wrap modulo 4·DEPTH_WORDS bytes.

## Test plan
- WAIT_STATES=2: SW 0xDEADBEEF at 0x10 accepted edge 0 → `Ready` after edge 3, `Busy` high cycles 1–3; LW 0x10 → ReadData=0xDEADBEEF.
- SB 0x7F at 0x11 over 0xDEADBEEF → LW 0x10 = 0xDEAD7FEF; LB 0x13 = 0xFFFFFFDE; LBU 0x13 = 0x000000DE; LH 0x12 = 0xFFFFDEAD.
- LH at 0x21, LW at 0x22, Size=11, MemRead+MemWrite together → each `Ready`=`Error`=1, memory and ReadData unchanged.
- WAIT_STATES=0 back-to-back SW/LW/LW to same address → one result per 2 cycles, second LW returns stored value.
- Assert `reset_n`=0 during WAIT of an SW → no write (later LW returns prior value), all outputs 0 next cycle.
- DEPTH_WORDS=256, SW to 0x400: without macro aliases address 0x000; with `D_MEM_BOUNDS_CHECK_EN` → `Error`=1, 0x000 unchanged.
